// File: rtl/sine_phase_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sine_phase_reader
//  Purpose  : Phase-accumulator sine sample reader. An N-bit phase is folded
//             onto an external quarter-wave magnitude ROM. Odd quadrants
//             mirror the address and the upper two quadrants negate the
//             magnitude. One signed sample comes out per generate_next
//             request, fully pipelined with one request per cycle.
//  Revision : 1.0  - first parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1          clock
//    reset         in   1          synchronous, active-high reset
//    step_size     in   PHASE_W    phase increment per sample (unsigned)
//    generate_next in   1          request one sample (may be held high)
//    phase_clr     in   1          restart the phase at 0
//    amp           in   8          output gain, only with SINE_READER_AMP_EN
//    rom_addr      out  ADDR_W     registered quarter-wave ROM address
//    rom_data      in   SAMPLE_W-1 ROM magnitude, one cycle after rom_addr
//    sample        out  SAMPLE_W   signed sample, held between updates
//    sample_ready  out  1          one-cycle pulse when sample updates
//
//  Build option
//    SINE_READER_AMP_EN : adds the amp input and one gain stage. Latency
//                         from request to sample_ready grows from 3 to 4.
// ============================================================================
module sine_phase_reader #(
    parameter int PHASE_W  = 22,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PHASE_W-1:0]         step_size,
    input  logic                       generate_next,
    input  logic                       phase_clr,
`ifdef SINE_READER_AMP_EN
    input  logic [7:0]                 amp,
`endif
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [SAMPLE_W-2:0]        rom_data,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_ready
);

    // ------------------------------------------------------------------------
    // Pipeline registers
    //   stage 0 : phase, rom_addr, s1/v1 (request accepted)
    //   stage 1 : s2/v2 (ROM is reading its data during this stage)
    //   stage 2 : signed sample (or signed value before gain)
    //   stage 3 : gained sample (gain build only)
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0]  phase_q,        phase_d;
    logic [ADDR_W-1:0]   rom_addr_q,     rom_addr_d;
    logic                s1_q,           s1_d;
    logic                v1_q,           v1_d;
    logic                s2_q,           s2_d;
    logic                v2_q,           v2_d;
    logic [SAMPLE_W-1:0] sample_q,       sample_d;
    logic                sample_ready_q, sample_ready_d;

`ifdef SINE_READER_AMP_EN
    logic [SAMPLE_W-1:0] val3_q,         val3_d;
    logic                v3_q,           v3_d;
    // Product of the sign-extended value and the zero-extended gain. The
    // true product always fits this width, so the low bits of an unsigned
    // multiply of the extended operands are the exact signed product.
    logic [SAMPLE_W+8:0] w_prod;
    logic [SAMPLE_W+8:0] w_val_ext;
    logic [SAMPLE_W+8:0] w_amp_ext;
    logic                w_unused_prod;
`endif

    // ------------------------------------------------------------------------
    // Stage 0 decode
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0]  w_phase_eff;
    logic [1:0]          w_quad;
    logic [ADDR_W-1:0]   w_index;
    logic [ADDR_W-1:0]   w_fold_addr;
    logic                w_neg;

    // Stage 2 sign application
    logic [SAMPLE_W-1:0] w_mag_ext;
    logic [SAMPLE_W-1:0] w_signed_val;

    always_comb begin
        // A restart applies to the request issued in the same cycle, so
        // the decode works from the cleared phase rather than phase_q.
        w_phase_eff = phase_clr ? '0 : phase_q;
        w_quad      = w_phase_eff[PHASE_W-1 -: 2];
        w_index     = w_phase_eff[PHASE_W-3 -: ADDR_W];
        // Quadrants 1 and 3 run the quarter wave backwards.
        w_fold_addr = w_quad[0] ? ~w_index : w_index;
        // Quadrants 2 and 3 are the negative half-cycle.
        w_neg       = w_quad[1];
    end

    always_comb begin
        // Magnitude is strictly below 2^(SAMPLE_W-1), so negation of the
        // zero-extended value never overflows and -0 stays 0.
        w_mag_ext    = {1'b0, rom_data};
        w_signed_val = s2_q ? (~w_mag_ext + 1'b1) : w_mag_ext;
    end

`ifdef SINE_READER_AMP_EN
    always_comb begin
        w_val_ext     = {{9{val3_q[SAMPLE_W-1]}}, val3_q};
        w_amp_ext     = {{(SAMPLE_W+1){1'b0}}, amp};
        w_prod        = w_val_ext * w_amp_ext;
        // Bits below the shift point and the duplicate sign bit are not
        // part of the gained result.
        w_unused_prod = ^{w_prod[7:0], w_prod[SAMPLE_W+8]};
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        phase_d        = phase_q;
        rom_addr_d     = rom_addr_q;
        s1_d           = s1_q;
        v1_d           = generate_next;
        s2_d           = s1_q;
        v2_d           = v1_q;
        sample_d       = sample_q;
        sample_ready_d = 1'b0;

        // Stage 0: accept a request, or service a standalone restart.
        // Phase wraps modulo 2^PHASE_W by construction of the adder width.
        if (generate_next) begin
            rom_addr_d = w_fold_addr;
            s1_d       = w_neg;
            phase_d    = w_phase_eff + step_size;
        end else if (phase_clr) begin
            phase_d    = '0;
        end

`ifdef SINE_READER_AMP_EN
        val3_d = val3_q;
        v3_d   = v2_q;
        if (v2_q) begin
            val3_d = w_signed_val;
        end
        // Arithmetic shift by 8 of the product: floor(value * amp / 256).
        if (v3_q) begin
            sample_d = w_prod[SAMPLE_W+7:8];
        end
        sample_ready_d = v3_q;
`else
        if (v2_q) begin
            sample_d = w_signed_val;
        end
        sample_ready_d = v2_q;
`endif
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops every in-flight request by clearing all
    // valid bits, so no sample_ready can follow a reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= '0;
            rom_addr_q     <= '0;
            s1_q           <= 1'b0;
            v1_q           <= 1'b0;
            s2_q           <= 1'b0;
            v2_q           <= 1'b0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            rom_addr_q     <= rom_addr_d;
            s1_q           <= s1_d;
            v1_q           <= v1_d;
            s2_q           <= s2_d;
            v2_q           <= v2_d;
            sample_q       <= sample_d;
            sample_ready_q <= sample_ready_d;
        end
    end

`ifdef SINE_READER_AMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            val3_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            val3_q <= val3_d;
            v3_q   <= v3_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_ready = sample_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_sine_phase_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sine_phase_reader
//  Purpose  : Self-checking bench for sine_phase_reader. A behavioural model
//             turns each request's phase into the expected ROM address and
//             signed sample and schedules when sample_ready must pulse.
//  Revision : 1.0
// ============================================================================
module tb_sine_phase_reader;

    localparam int PHASE_W  = 22;
    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 16;
`ifdef SINE_READER_AMP_EN
    localparam int LAT      = 3;   // edges from request edge to ready edge
    localparam int AMP_VAL  = 128;
`else
    localparam int LAT      = 2;
`endif

    localparam int E2[4] = '{0, 16368, 0, -16368};
    localparam int E4[3] = '{0, 0, -16};
    localparam int E5[5] = '{0, 16, 32, 0, 16};

    typedef struct {
        int due;
        int val;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [PHASE_W-1:0]         step_size;
    logic                       generate_next;
    logic                       phase_clr;
    logic [ADDR_W-1:0]          rom_addr;
    logic [SAMPLE_W-2:0]        rom_data;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_ready;
`ifdef SINE_READER_AMP_EN
    logic [7:0]                 amp;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    int unsigned m_phase  = 0;
    int          m_addr   = 0;
    int          m_sample = 0;
    exp_t        pend[$];
    int          got[$];

    sine_phase_reader #(
        .PHASE_W  (PHASE_W),
        .ADDR_W   (ADDR_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .step_size     (step_size),
        .generate_next (generate_next),
        .phase_clr     (phase_clr),
`ifdef SINE_READER_AMP_EN
        .amp           (amp),
`endif
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sample        (sample),
        .sample_ready  (sample_ready)
    );

    always #5 clk = ~clk;

    // Quarter-wave ROM: rom[k] = 16*k, registered read.
    always @(posedge clk) rom_data <= {1'b0, rom_addr, 4'b0000};

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int ref_addr(input int unsigned p);
        int unsigned quad, idx;
        quad = p / (1 << (PHASE_W - 2));
        idx  = (p / (1 << (PHASE_W - 2 - ADDR_W))) % (1 << ADDR_W);
        return int'((quad % 2 == 1) ? ((1 << ADDR_W) - 1 - idx) : idx);
    endfunction

    function automatic int scale(input int v);
`ifdef SINE_READER_AMP_EN
        int prod;
        prod = v * AMP_VAL;
        return prod >>> 8;
`else
        return v;
`endif
    endfunction

    function automatic int ref_sample(input int unsigned p);
        int unsigned quad;
        int mag;
        quad = p / (1 << (PHASE_W - 2));
        mag  = 16 * ref_addr(p);
        return scale((quad >= 2) ? -mag : mag);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic tick(input bit gen, input bit clr,
                        input logic [PHASE_W-1:0] step, input bit rst);
        int unsigned p;
        generate_next = gen;
        phase_clr     = clr;
        step_size     = step;
        reset         = rst;
        if (rst) begin
            pend.delete();
            m_phase  = 0;
            m_addr   = 0;
            m_sample = 0;
        end else if (gen) begin
            p = clr ? 0 : m_phase;
            pend.push_back('{due: edge_n + 1 + LAT, val: ref_sample(p)});
            m_addr  = ref_addr(p);
            m_phase = (p + step) % (1 << PHASE_W);
        end else if (clr) begin
            m_phase = 0;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        chk($sformatf("rom_addr@%0d", edge_n), rom_addr, m_addr);
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            m_sample = pend[0].val;
            void'(pend.pop_front());
            chk($sformatf("ready@%0d", edge_n), sample_ready, 1);
        end else begin
            chk($sformatf("ready@%0d", edge_n), sample_ready, 0);
        end
        chk($sformatf("sample@%0d", edge_n), sample, m_sample);
        if (sample_ready === 1'b1) got.push_back(int'(sample));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, '0, 0);
    endtask

    task automatic chk_got(input string tag, input int idx, input int exp);
        chk($sformatf("%s_%0d", tag, idx),
            (idx < got.size()) ? got[idx] : 32'sh7fff_dead, scale(exp));
    endtask

    initial begin
        reset         = 1'b1;
        generate_next = 1'b0;
        phase_clr     = 1'b0;
        step_size     = '0;
`ifdef SINE_READER_AMP_EN
        amp           = 8'(AMP_VAL);
`endif

        // Reset state
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        idle(2);

        // 1: single requests, ready exactly three cycles later
        got.delete();
        tick(1, 0, 22'h000400, 0);
        idle(4);
        tick(1, 0, 22'h000400, 0);
        idle(4);
        chk("t1_count", got.size(), 2);
        chk_got("t1", 0, 0);
        chk_got("t1", 1, 16);

        // 2: quadrant fold
        tick(0, 1, '0, 0);
        got.delete();
        for (int k = 0; k < 4; k++) tick(1, 0, 22'h100000, 0);
        idle(5);
        chk("t2_count", got.size(), 4);
        for (int k = 0; k < 4; k++) chk_got("t2", k, E2[k]);

        // 3: streaming
        tick(0, 1, '0, 0);
        got.delete();
        for (int k = 0; k < 8; k++) tick(1, 0, 22'h000400, 0);
        idle(5);
        chk("t3_count", got.size(), 8);
        for (int k = 0; k < 8; k++) chk_got("t3", k, 16 * k);

        // 4: wrap and mirror
        tick(0, 1, '0, 0);
        got.delete();
        for (int k = 0; k < 3; k++) tick(1, 0, 22'h3FFC00, 0);
        idle(5);
        chk("t4_count", got.size(), 3);
        for (int k = 0; k < 3; k++) chk_got("t4", k, E4[k]);

        // 5: phase_clr with a request while earlier samples are in flight
        tick(0, 1, '0, 0);
        got.delete();
        for (int k = 0; k < 3; k++) tick(1, 0, 22'h000400, 0);
        tick(1, 1, 22'h000400, 0);
        tick(1, 0, 22'h000400, 0);
        idle(5);
        chk("t5_count", got.size(), 5);
        for (int k = 0; k < 5; k++) chk_got("t5", k, E5[k]);

        // 6: reset one cycle after a request drops it
        got.delete();
        tick(1, 0, 22'h000400, 0);
        tick(0, 0, '0, 1);
        idle(5);
        chk("t6_count", got.size(), 0);
        chk("t6_sample", sample, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit rst_r, gen_r, clr_r;
            logic [PHASE_W-1:0] st;
            rst_r = ($urandom_range(0, 63) == 0);
            gen_r = rst_r ? 1'b0 : ($urandom_range(0, 3) != 0);
            clr_r = ($urandom_range(0, 15) == 0);
            st    = ($urandom_range(0, 1) == 0) ? PHASE_W'($urandom)
                                                : PHASE_W'($urandom_range(0, 4096));
            tick(gen_r, clr_r, st, rst_r);
        end
        idle(5);
        chk("rand_drained", pend.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sine_phase_reader.md
Name: sine_phase_reader

Overview:
- Parametrised successor of the first-generation sine sample reader.
- Holds an N-bit phase accumulator and folds it onto a quarter-wave magnitude ROM by mirroring the address and negating the sign.
- Produces one signed sample per `generate_next` request, fully pipelined.
- Sits between the note/frequency logic (which supplies `step_size`) and the codec sample path. The ROM is external, on a registered-read port.

Parameters:
- PHASE_W, 22: phase accumulator width. Top 2 bits are the quadrant, next ADDR_W bits are the ROM index, the remainder is fraction.
- ADDR_W, 10: quarter-wave ROM address width (2^ADDR_W entries).
- SAMPLE_W, 16: signed output sample width. ROM magnitudes are in 0..2^(SAMPLE_W-1)-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- step_size  in  PHASE_W  phase increment per sample, unsigned.
- generate_next  in  1  request one sample; may be high every cycle.
- phase_clr  in  1  force the accumulator to 0 (note restart).
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_data  in  SAMPLE_W-1  ROM magnitude, valid one cycle after rom_addr.
- sample  out  SAMPLE_W  signed two's-complement sample; holds its value between updates.
- sample_ready  out  1  one-cycle pulse: sample was updated this cycle.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: phase=0, rom_addr=0, sample=0, sample_ready=0, all pipeline valid and sign bits=0.
- Reset mid-operation drops every in-flight request; no sample_ready follows a reset.
- Phase decode: q = phase[PHASE_W-1:PHASE_W-2], i = phase[PHASE_W-3:PHASE_W-2-ADDR_W].
- Address mirror: ROM address = i when q[0]=0; address = ~i (that is, 2^ADDR_W-1-i) when q[0]=1.
- Sign: negative when q[1]=1.
- Stage 0 (edge where generate_next=1):
  - Register rom_addr from the current phase.
  - Register sign bit s1 and valid v1.
  - Update phase <= phase + step_size, modulo 2^PHASE_W; wrap is silent.
  - step_size is sampled at this edge only.
- Stage 1: ROM registers its data. s1 moves to s2, v1 to v2.
- Stage 2: on v2, sample <= s2 ? -zext(rom_data) : zext(rom_data). sample_ready <= v2.
  - Negating 0 gives 0. No overflow is possible, since the magnitude is below 2^(SAMPLE_W-1).
- Latency: generate_next high in cycle N gives sample_ready high in cycle N+3. Throughput is one sample per cycle, order preserved.
- When generate_next=0: phase holds, rom_addr holds, and no request enters the pipe.
- phase_clr:
  - Alone: phase <= 0 next edge.
  - Together with generate_next: the current request uses phase 0 (address 0, positive sign), and phase <= step_size.
- Requests already in flight complete normally across a phase_clr.
- step_size=0: every sample repeats the same value.
- Any step_size is allowed. Values ≥ 2^(PHASE_W-1) alias (reverse or skip); the block does not flag this.

Optional Feature:
- Macro SINE_READER_AMP_EN.
- When defined:
  - Adds input `amp`, 8 bits, unsigned gain.
  - Adds one register stage: sample <= (signed stage-2 value × {1'b0,amp}) >>> 8, arithmetic shift.
  - amp is sampled at the stage-3 edge. amp=0 gives 0; amp=255 gives value×255/256, truncated toward −∞.
  - Latency becomes N+4. Reset also clears the extra stage.
- When undefined: no amp port, latency N+3, and the output equals the ROM value with its sign applied.

Test Plan:
Bench defaults and ROM model: parameters at default values; ROM model rom[k]=16·k (max 16368); 1-cycle registered read.
1. Single request: reset, step_size=0x000400, generate_next pulsed once in cycle N → sample_ready high only in N+3, sample=0, rom_addr=0; next pulse gives sample=16.
2. Quadrant fold: step_size=0x100000, four back-to-back requests → rom_addr 0,1023,0,1023; samples 0, 16368, 0, −16368.
3. Streaming: step_size=0x000400, generate_next high for 8 cycles → 8 consecutive sample_ready pulses in cycles N+3..N+10; samples 0,16,…,112.
4. Wrap and mirror: from phase 0, step_size=0x3FFC00, three requests → phases 0, 0x3FFC00, 0x3FF800; rom_addr 0,0,1; samples 0, 0, −16; phase wraps silently.
5. phase_clr together with generate_next after streaming with step 0x400 → that sample=0. The following request uses phase 0x400 and gives sample=16. Earlier in-flight samples are unaffected.
6. Reset mid-flight: generate_next in cycle N, reset in cycle N+1 → no sample_ready in N+3, sample=0. With SINE_READER_AMP_EN and amp=128, test 2 yields 0, 8184, 0, −8184 at N+4.
